// File: rtl/calendar_uart_tx.sv
// Serial time reporter: snapshots Hours/Mins/Secs on Start and transmits
// "HH:MM:SS\r\n" as ten 8N1 characters, LSB first, with registered TXD.
module calendar_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic       Start,
    output logic       TXD,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned CHAR_W    = 4;
    localparam int unsigned BIT_W     = 3;
    localparam int unsigned VAL_W     = 6;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CHAR_W-1:0] LAST_CHAR = CHAR_W'(9);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(7);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              state, state_n;
    logic [VAL_W-1:0]    snap_h, snap_m, snap_s;
    logic [VAL_W-1:0]    snap_h_n, snap_m_n, snap_s_n;
    logic [CHAR_W-1:0]   char_idx, char_idx_n;
    logic [BIT_W-1:0]    bit_idx, bit_idx_n;
    logic [CNT_W-1:0]    baud_cnt, baud_cnt_n;
    logic                txd_n, busy_n, done_n;
    logic                bit_end;
    logic [7:0]          next_char;

    // ASCII tens digit of a 6-bit value (values above 59 are encoded literally)
    function automatic logic [7:0] ascii_tens(input logic [VAL_W-1:0] v);
        return 8'h30 + 8'(v / VAL_W'(10));
    endfunction

    // ASCII ones digit of a 6-bit value
    function automatic logic [7:0] ascii_ones(input logic [VAL_W-1:0] v);
        return 8'h30 + 8'(v % VAL_W'(10));
    endfunction

    // Character at position idx of the line "HH:MM:SS\r\n"
    function automatic logic [7:0] frame_char(
        input logic [CHAR_W-1:0] idx,
        input logic [VAL_W-1:0]  h,
        input logic [VAL_W-1:0]  m,
        input logic [VAL_W-1:0]  s
    );
        logic [7:0] c;
        c = 8'h0A;
        case (idx)
            4'd0:    c = ascii_tens(h);
            4'd1:    c = ascii_ones(h);
            4'd2:    c = 8'h3A;
            4'd3:    c = ascii_tens(m);
            4'd4:    c = ascii_ones(m);
            4'd5:    c = 8'h3A;
            4'd6:    c = ascii_tens(s);
            4'd7:    c = ascii_ones(s);
            4'd8:    c = 8'h0D;
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // State and output registers; reset forces the line idle immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            snap_h   <= '0;
            snap_m   <= '0;
            snap_s   <= '0;
            char_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            TXD      <= 1'b1;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_n;
            snap_h   <= snap_h_n;
            snap_m   <= snap_m_n;
            snap_s   <= snap_s_n;
            char_idx <= char_idx_n;
            bit_idx  <= bit_idx_n;
            baud_cnt <= baud_cnt_n;
            TXD      <= txd_n;
            Busy     <= busy_n;
            Done     <= done_n;
        end
    end

    // Next-state logic; outputs are derived from the next state so they
    // appear on the pins at the same edge the state changes
    always_comb begin
        state_n    = state;
        snap_h_n   = snap_h;
        snap_m_n   = snap_m;
        snap_s_n   = snap_s;
        char_idx_n = char_idx;
        bit_idx_n  = bit_idx;
        baud_cnt_n = baud_cnt;
        done_n     = 1'b0;
        txd_n      = 1'b1;
        next_char  = 8'h00;
        bit_end    = (baud_cnt == BAUD_LAST);

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_n    = S_START;
                    snap_h_n   = Hours;
                    snap_m_n   = Mins;
                    snap_s_n   = Secs;
                    char_idx_n = '0;
                    bit_idx_n  = '0;
                    baud_cnt_n = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n    = S_DATA;
                    bit_idx_n  = '0;
                    baud_cnt_n = '0;
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + BIT_W'(1);
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_cnt_n = '0;
                    if (char_idx < LAST_CHAR) begin
                        char_idx_n = char_idx + CHAR_W'(1);
                        state_n    = S_START;
                    end else begin
                        char_idx_n = '0;
                        state_n    = S_IDLE;
                        done_n     = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        next_char = frame_char(char_idx_n, snap_h_n, snap_m_n, snap_s_n);
        busy_n    = (state_n != S_IDLE);

        case (state_n)
            S_START: txd_n = 1'b0;
            S_DATA:  txd_n = next_char[bit_idx_n];
            default: txd_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_calendar_uart_tx.sv
// Self-checking bench for calendar_uart_tx: a string-based line model gives the
// expected 100-bit frame, checked every cycle and by mid-bit receiver decode.
module tb_calendar_uart_tx;

    localparam int unsigned CPB1 = 16;
    localparam int unsigned CPB2 = 2;

    logic       CLK;
    logic       RST;
    logic [5:0] hours, mins, secs;
    logic       start1, start2;
    logic       txd1, busy1, done1;
    logic       txd2, busy2, done2;

    int checks = 0;
    int errors = 0;

    logic [99:0] exp_bits;
    logic [7:0]  exp_ch [10];

    calendar_uart_tx #(.CLKS_PER_BIT(CPB1)) u_dut (
        .CLK(CLK), .RST(RST), .Hours(hours), .Mins(mins), .Secs(secs),
        .Start(start1), .TXD(txd1), .Busy(busy1), .Done(done1)
    );

    calendar_uart_tx #(.CLKS_PER_BIT(CPB2)) u_dut2 (
        .CLK(CLK), .RST(RST), .Hours(hours), .Mins(mins), .Secs(secs),
        .Start(start2), .TXD(txd2), .Busy(busy2), .Done(done2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line built as text, then laid out as start/data/stop bits
    task automatic set_expected(input int h, input int m, input int s);
        string str;
        str = $sformatf("%02d:%02d:%02d", h, m, s);
        for (int i = 0; i < 8; i++) exp_ch[i] = str[i];
        exp_ch[8] = 8'h0D;
        exp_ch[9] = 8'h0A;
        for (int i = 0; i < 10; i++) begin
            exp_bits[i*10] = 1'b0;
            for (int j = 0; j < 8; j++) exp_bits[i*10+1+j] = exp_ch[i][j];
            exp_bits[i*10+9] = 1'b1;
        end
    endtask

    task automatic start_frame(input bit sel, input int h, input int m, input int s);
        @(negedge CLK);
        hours = 6'(h); mins = 6'(m); secs = 6'(s);
        if (sel) start2 = 1'b1; else start1 = 1'b1;
    endtask

    // Follows one frame from its accept edge; optional mid-frame re-request or reset
    task automatic run_frame(input bit sel, input int cpb, input int h, input int m, input int s,
                             input int inject_at, input int abort_at, input bit hold, input bit tail);
        logic [99:0] rx;
        logic t, b, d;
        rx = '0;
        set_expected(h, m, s);
        @(posedge CLK); #1;
        for (int c = 0; c < 100 * cpb; c++) begin
            t = sel ? txd2 : txd1;
            b = sel ? busy2 : busy1;
            d = sel ? done2 : done1;
            if (c == 0 && !hold) begin
                if (sel) start2 = 1'b0; else start1 = 1'b0;
            end
            if (c == abort_at) begin
                RST = 1'b1;
                #1;
                check("rst_txd", sel ? txd2 : txd1, 1);
                check("rst_busy", sel ? busy2 : busy1, 0);
                check("rst_done", sel ? done2 : done1, 0);
                repeat (3) begin
                    @(posedge CLK); #1;
                    check("rst_hold_txd", sel ? txd2 : txd1, 1);
                    check("rst_hold_done", sel ? done2 : done1, 0);
                end
                @(negedge CLK);
                RST = 1'b0;
                repeat (5) begin
                    @(posedge CLK); #1;
                    check("post_rst_busy", sel ? busy2 : busy1, 0);
                    check("post_rst_done", sel ? done2 : done1, 0);
                end
                return;
            end
            check("txd", t, exp_bits[c/cpb]);
            check("busy", b, 1);
            check("done_low", d, 0);
            if (c % cpb == cpb / 2) rx[c/cpb] = t;
            if (c == inject_at) begin
                hours = 6'd4; mins = 6'd5; secs = 6'd6;
                start1 = 1'b1;
            end
            if (c == inject_at + 1) start1 = 1'b0;
            @(posedge CLK); #1;
        end
        check("done_pulse", sel ? done2 : done1, 1);
        check("busy_fall", sel ? busy2 : busy1, 0);
        check("idle_txd", sel ? txd2 : txd1, 1);
        for (int i = 0; i < 10; i++) check("rx_char", rx[i*10+1 +: 8], exp_ch[i]);
        if (tail) begin
            @(posedge CLK); #1;
            check("done_fall", sel ? done2 : done1, 0);
            check("busy_idle", sel ? busy2 : busy1, 0);
        end
    endtask

    initial begin
        int h, m, s;
        RST = 1'b1; start1 = 1'b0; start2 = 1'b0;
        hours = '0; mins = '0; secs = '0;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_txd", txd1, 1);
        check("reset_busy", busy1, 0);
        check("reset_done", done1, 0);
        check("reset_txd2", txd2, 1);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) begin
            @(posedge CLK); #1;
            check("idle_txd", txd1, 1);
            check("idle_busy", busy1, 0);
            check("idle_done", done1, 0);
        end

        start_frame(0, 12, 34, 56);
        run_frame(0, CPB1, 12, 34, 56, -1, -1, 0, 1);

        start_frame(0, 0, 0, 0);
        run_frame(0, CPB1, 0, 0, 0, -1, -1, 0, 1);
        start_frame(0, 23, 59, 59);
        run_frame(0, CPB1, 23, 59, 59, -1, -1, 0, 1);
        start_frame(0, 63, 60, 9);
        run_frame(0, CPB1, 63, 60, 9, -1, -1, 0, 1);

        for (int i = 0; i < 3; i++) begin
            h = int'($urandom_range(0, 63));
            m = int'($urandom_range(0, 63));
            s = int'($urandom_range(0, 63));
            start_frame(0, h, m, s);
            run_frame(0, CPB1, h, m, s, -1, -1, 0, 1);
        end

        // Second request and input change during a frame are ignored
        start_frame(0, 1, 2, 3);
        run_frame(0, CPB1, 1, 2, 3, 300, -1, 0, 1);
        repeat (40) begin
            @(posedge CLK); #1;
            check("no_refire_busy", busy1, 0);
            check("no_refire_txd", txd1, 1);
            check("no_refire_done", done1, 0);
        end

        // Reset during character 4, then a fresh complete frame
        start_frame(0, 7, 8, 9);
        run_frame(0, CPB1, 7, 8, 9, -1, 45 * CPB1, 0, 1);
        start_frame(0, 10, 20, 30);
        run_frame(0, CPB1, 10, 20, 30, -1, -1, 0, 1);

        // Start held high at two cycles per bit: one idle cycle between frames
        h = int'($urandom_range(0, 63)); m = int'($urandom_range(0, 63)); s = int'($urandom_range(0, 63));
        start_frame(1, h, m, s);
        run_frame(1, CPB2, h, m, s, -1, -1, 1, 0);
        h = int'($urandom_range(0, 63)); m = int'($urandom_range(0, 63)); s = int'($urandom_range(0, 63));
        hours = 6'(h); mins = 6'(m); secs = 6'(s);
        run_frame(1, CPB2, h, m, s, -1, -1, 1, 0);
        h = int'($urandom_range(0, 63)); m = int'($urandom_range(0, 63)); s = int'($urandom_range(0, 63));
        hours = 6'(h); mins = 6'(m); secs = 6'(s);
        run_frame(1, CPB2, h, m, s, -1, -1, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/calendar_uart_tx.md
# calendar_uart_tx

Serial time reporter for the time-of-day counter. On request it snapshots the 6-bit binary Hours/Mins/Secs values, converts each to two ASCII decimal digits, and transmits the line "HH:MM:SS\r\n" over a UART transmit line (8N1, LSB first). It sits between the calendar counter outputs and the board's debug UART pin.

## Interface
- CLKS_PER_BIT, default 16: CLK cycles per UART bit; legal range 2..65535.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- Hours  input  6  binary hours, nominal range 0..23.
- Mins  input  6  binary minutes, nominal range 0..59.
- Secs  input  6  binary seconds, nominal range 0..59.
- Start  input  1  transmit request; sampled on the rising edge of CLK.
- TXD  output  1  UART serial output; idles high.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse when the last stop bit completes.

## Operation
- Outputs on reset: TXD=1, Busy=0, Done=0. State is IDLE. Snapshot registers, character index, bit index and baud counter are all 0.
- Accept condition: Start=1 while Busy=0 at a rising edge. At that edge:
  - Hours, Mins and Secs are copied into snapshot registers.
  - Busy goes to 1 and the FSM goes to START for character 0.
- Start is ignored while Busy=1. Input changes after the accepting edge have no effect on the frame.
- Frame content is 10 characters, in this order:
  - tens(H), ones(H), 0x3A, tens(M), ones(M), 0x3A, tens(S), ones(S), 0x0D, 0x0A.
  - Each digit is 0x30 + the decimal digit.
  - tens = value/10 and ones = value%10, computed on the 6-bit snapshot.
- Out-of-range values are not clamped. They are encoded literally, e.g. 63 gives "63".
- FSM states:
  - IDLE: TXD=1. Goes to START on accept.
  - START: TXD=0 for CLKS_PER_BIT cycles, then goes to DATA with bit index 0.
  - DATA: TXD = char[bit index] for CLKS_PER_BIT cycles per bit, bits 0..7, LSB first. After bit 7, goes to STOP.
  - STOP: TXD=1 for CLKS_PER_BIT cycles. Then:
    - if character index < 9: increment the index and go to START (no inter-character gap);
    - otherwise: go to IDLE, Busy goes to 0 and Done goes to 1 for one cycle.
- The baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Its width is ceil(log2(CLKS_PER_BIT)), with a minimum of 1 bit.
- Reset mid-frame: TXD returns to 1 and Busy to 0 immediately (asynchronously). The frame is abandoned and no Done pulse is produced. The next accepted Start sends a complete fresh frame.

## Timing
- Accept at edge k: TXD=0 and Busy=1 are visible from edge k onward (registered outputs). There is no extra latency cycle.
- Bit n of the frame (n = 0..99) is driven from edge k + n·CLKS_PER_BIT until edge k + (n+1)·CLKS_PER_BIT.
  - Frame bit n = character index·10 + bit position within the character.
- Busy is high for exactly 100·CLKS_PER_BIT cycles.
- Done pulse: at edge k + 100·CLKS_PER_BIT, Busy falls and Done=1 for exactly one cycle. Done falls at the next edge.
- Back-to-back requests:
  - Start=1 at edge k + 100·CLKS_PER_BIT is ignored, because Busy is still 1 before that edge.
  - Start=1 at the following edge is accepted.
  - The minimum idle gap between frames is therefore one cycle.
- Start held high continuously gives back-to-back frames separated by one idle cycle. Each frame re-samples the time inputs.
- TXD is driven directly from a register, so there is no combinational glitch on the pin.

## Test plan
- Reset with RST=1 then release → TXD=1, Busy=0, Done=0 throughout; no TXD activity without Start.
- CLKS_PER_BIT=16, Hours=12, Mins=34, Secs=56, one-cycle Start pulse → receiver model decodes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0D 0x0A. Each bit lasts 16 cycles, Busy is high for 1600 cycles, and Done pulses exactly once, at cycle 1600 after accept.
- Boundary values: 0/0/0 → "00:00:00\r\n"; 23/59/59 → "23:59:59\r\n"; 63/60/9 → "63:60:09\r\n".
- Accept with 1/2/3, then change inputs to 4/5/6 and pulse Start again during the frame → exactly one frame, "01:02:03\r\n", and one Done pulse.
- Assert RST during character 4 → TXD=1 and Busy=0 in the same cycle, no Done. Then Start with 10/20/30 → a complete, correct "10:20:30\r\n" frame.
- CLKS_PER_BIT=2 with Start held high → consecutive frames separated by exactly one idle cycle (TXD=1, Busy=0); each frame reflects the inputs sampled at its own accept edge.
